rv_multicycle_ctrl: RTL and testbench

Multi-cycle control unit for the RV32I core: a state machine that sequences fetch, decode, execute, memory and write-back over a single shared memory port with a ready handshake. It drives the register file, PC, instruction register and ALU control signals, using the same control encodings as the single-cycle decoder. Compared with that decoder it adds JALR, AUIPC, SLTU and immediate shifts, plus memory wait states, a bus timeout and illegal-opcode trapping.

---
 rtl/rv_multicycle_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB over one shared memory
// port, with wait states, bus timeout and illegal-opcode trapping.
module rv_multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       br_cond,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_a_sel,
  output logic       alu_src,
  output logic [2:0] imm_sel,
  output logic [3:0] alu_ctrl,
  output logic       instret,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  state_t          state, state_next;
  logic [TO_W-1:0] wait_cnt;
  logic [1:0]      cause_q, cause_next;
  logic            timeout_hit;
  logic            is_r, is_ialu, is_lw, is_sw, is_br, is_jal, is_jalr, is_lui, is_auipc, legal;
  logic            unused_funct7;

  assign is_r     = (opcode == OP_R);
  assign is_ialu  = (opcode == OP_IALU);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_br    = (opcode == OP_BR);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign is_lui   = (opcode == OP_LUI);
  assign is_auipc = (opcode == OP_AUIPC);
  assign legal    = is_r | is_ialu | is_lw | is_sw | is_br | is_jal | is_jalr | is_lui | is_auipc;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // Fires on the wait cycle that would bring the counter to TIMEOUT; a ready
  // in that same cycle takes precedence.
  assign timeout_hit = (TIMEOUT != 0) && !mem_ready && (int'(wait_cnt) == TIMEOUT - 1);

  assign fsm_state = state;

  // Register-register and register-immediate share one table; only R-type may subtract.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt,
                                            input logic allow_sub);
    case (f3)
      3'b000:  alu_decode = (alt && allow_sub) ? 4'd1 : 4'd0;
      3'b001:  alu_decode = 4'd2;
      3'b010:  alu_decode = 4'd3;
      3'b011:  alu_decode = 4'd4;
      3'b100:  alu_decode = 4'd5;
      3'b101:  alu_decode = alt ? 4'd7 : 4'd6;
      3'b110:  alu_decode = 4'd8;
      default: alu_decode = 4'd9;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      cause_q  <= 2'b00;
    end else begin
      state   <= state_next;
      cause_q <= cause_next;
      if (state_next != state)
        wait_cnt <= '0;
      else if ((state == S_FETCH || state == S_MEM) && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    cause_next = cause_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 2'b00;
    rf_we      = 1'b0;
    wb_sel     = 2'b00;
    alu_a_sel  = 2'b00;
    alu_src    = 1'b0;
    imm_sel    = 3'b000;
    alu_ctrl   = 4'd0;
    instret    = 1'b0;
    trap       = 1'b0;
    trap_cause = cause_q;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we      = 1'b1;
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          cause_next = 2'b10;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          state_next = S_TRAP;
          cause_next = 2'b01;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        state_next = S_WB;
        if (is_r) begin
          alu_ctrl = alu_decode(funct3, funct7[5], 1'b1);
        end else if (is_ialu) begin
          alu_ctrl = alu_decode(funct3, funct7[5], 1'b0);
          alu_src  = 1'b1;
        end else if (is_lw || is_sw) begin
          alu_src    = 1'b1;
          imm_sel    = is_sw ? 3'b001 : 3'b000;
          state_next = S_MEM;
        end else if (is_br) begin
          alu_ctrl   = 4'd1;
          imm_sel    = 3'b010;
          pc_we      = 1'b1;
          pc_sel     = br_cond ? 2'b01 : 2'b00;
          instret    = 1'b1;
          state_next = S_FETCH;
        end else if (is_jal) begin
          imm_sel = 3'b100;
          pc_sel  = 2'b01;
        end else if (is_jalr) begin
          alu_src = 1'b1;
          pc_sel  = 2'b10;
        end else begin
          alu_a_sel = is_auipc ? 2'b01 : 2'b10;
          alu_src   = 1'b1;
          imm_sel   = 3'b011;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = is_sw;
        if (mem_ready) begin
          if (is_sw) begin
            pc_we      = 1'b1;
            instret    = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          cause_next = 2'b10;
        end
      end
      S_WB: begin
        rf_we      = 1'b1;
        pc_we      = 1'b1;
        instret    = 1'b1;
        state_next = S_FETCH;
        if (is_lw)
          wb_sel = 2'b01;
        else if (is_jal || is_jalr)
          wb_sel = 2'b10;
        // JAL keeps the J immediate selected so PC+imm is valid at the PC update.
        if (is_jal) begin
          pc_sel  = 2'b01;
          imm_sel = 3'b100;
        end else if (is_jalr) begin
          pc_sel = 2'b10;
        end
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase

    // Reset suppresses every strobe in the cycle it is asserted.
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_sel     = 2'b00;
      rf_we      = 1'b0;
      wb_sel     = 2'b00;
      alu_a_sel  = 2'b00;
      alu_src    = 1'b0;
      imm_sel    = 3'b000;
      alu_ctrl   = 4'd0;
      instret    = 1'b0;
      trap       = 1'b0;
      trap_cause = 2'b00;
    end
  end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: expected state sequence per instruction is
// queued up front and popped cycle by cycle, plus per-class control checks.
module tb_rv_multicycle_ctrl;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic [6:0] funct7 = 7'd0;
  logic       br_cond = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_we, pc_we, rf_we, alu_src, instret, trap;
  logic [1:0] pc_sel, wb_sel, alu_a_sel, trap_cause;
  logic [2:0] imm_sel, fsm_state;
  logic [3:0] alu_ctrl;

  rv_multicycle_ctrl #(.TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .br_cond(br_cond), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .iord(iord), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .alu_a_sel(alu_a_sel), .alu_src(alu_src), .imm_sel(imm_sel),
    .alu_ctrl(alu_ctrl), .instret(instret), .trap(trap), .trap_cause(trap_cause),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  // Per-instruction observations, captured by expected state
  int         n_instret, last_cyc, rf_we_cnt, mem_we_cnt, mem_we_bad;
  logic [3:0] ex_alu_ctrl;
  logic       ex_alu_src, ex_pc_we, wb_rf_we;
  logic [2:0] ex_imm_sel;
  logic [1:0] ex_alu_a_sel, ex_pc_sel, wb_wb_sel, wb_pc_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction starting just after a rising edge with the DUT in FETCH.
  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic brc, input int wf, input int wm, input string tag);
    bit ld, st, br;
    int len, mstart;
    logic [2:0] st_exp;
    ld = (op == 7'b0000011);
    st = (op == 7'b0100011);
    br = (op == 7'b1100011);
    for (int i = 0; i < wf + 1; i++) exp_q.push_back(ST_FETCH);
    exp_q.push_back(ST_DECODE);
    exp_q.push_back(ST_EXEC);
    if (ld || st) for (int i = 0; i < wm + 1; i++) exp_q.push_back(ST_MEM);
    if (!br && !st) exp_q.push_back(ST_WB);
    len = exp_q.size();
    mstart = wf + 3;
    n_instret = 0; last_cyc = -1; rf_we_cnt = 0; mem_we_cnt = 0; mem_we_bad = 0;
    ex_alu_ctrl = 'x; ex_alu_src = 'x; ex_pc_we = 'x; ex_imm_sel = 'x;
    ex_alu_a_sel = 'x; ex_pc_sel = 'x; wb_rf_we = 'x; wb_wb_sel = 'x; wb_pc_sel = 'x;
    opcode = op; funct3 = f3; funct7 = f7; br_cond = brc;
    for (int c = 0; c < len; c++) begin
      mem_ready = !(c < wf) && !(c >= mstart && c < mstart + wm);
      @(negedge clk);
      st_exp = exp_q.pop_front();
      chk({tag, " state"}, 32'(fsm_state), 32'(st_exp));
      if (instret) begin n_instret++; last_cyc = c; end
      rf_we_cnt += int'(rf_we);
      if (mem_we) begin
        mem_we_cnt++;
        if (st_exp != ST_MEM) mem_we_bad++;
      end
      if (st_exp == ST_EXEC) begin
        ex_alu_ctrl = alu_ctrl; ex_alu_src = alu_src; ex_pc_we = pc_we;
        ex_imm_sel = imm_sel; ex_alu_a_sel = alu_a_sel; ex_pc_sel = pc_sel;
      end
      if (st_exp == ST_WB) begin
        wb_rf_we = rf_we; wb_wb_sel = wb_sel; wb_pc_sel = pc_sel;
      end
      @(posedge clk); #1;
    end
    chk({tag, " instret count"}, 32'(n_instret), 32'd1);
    chk({tag, " retire cycle"}, 32'(last_cyc), 32'(len - 1));
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset trap", 32'(trap), 32'd0);
    chk("reset trap_cause", 32'(trap_cause), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post reset state", 32'(fsm_state), 32'(ST_FETCH));
    chk("post reset mem_req", 32'(mem_req), 32'd1);
    chk("post reset iord", 32'(iord), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ir_we", 32'(ir_we), 32'd0);
    chk("reset pc_we", 32'(pc_we), 32'd0);
    chk("reset rf_we", 32'(rf_we), 32'd0);
    chk("reset alu_ctrl", 32'(alu_ctrl), 32'd0);
    reset_pulse();

    do_instr(7'b0110011, 3'b000, 7'b0000000, 1'b0, 0, 0, "add");
    chk("add alu_ctrl", 32'(ex_alu_ctrl), 32'd0);
    chk("add wb rf_we", 32'(wb_rf_we), 32'd1);
    chk("add wb_sel", 32'(wb_wb_sel), 32'd0);
    chk("add rf_we count", 32'(rf_we_cnt), 32'd1);

    do_instr(7'b0110011, 3'b000, 7'b0100000, 1'b0, 3, 0, "sub");
    chk("sub alu_ctrl", 32'(ex_alu_ctrl), 32'd1);
    do_instr(7'b0110011, 3'b011, 7'b0000000, 1'b0, 0, 0, "sltu");
    chk("sltu alu_ctrl", 32'(ex_alu_ctrl), 32'd4);

    do_instr(7'b0000011, 3'b010, 7'b0000000, 1'b0, 0, 2, "lw");
    chk("lw wb_sel", 32'(wb_wb_sel), 32'd1);
    chk("lw imm_sel", 32'(ex_imm_sel), 32'd0);
    chk("lw alu_src", 32'(ex_alu_src), 32'd1);

    do_instr(7'b0100011, 3'b010, 7'b0000000, 1'b0, 0, 1, "sw");
    chk("sw mem_we count", 32'(mem_we_cnt), 32'd2);
    chk("sw mem_we outside mem", 32'(mem_we_bad), 32'd0);
    chk("sw rf_we count", 32'(rf_we_cnt), 32'd0);
    chk("sw imm_sel", 32'(ex_imm_sel), 32'd1);

    do_instr(7'b1100011, 3'b000, 7'b0000000, 1'b1, 0, 0, "beq taken");
    chk("beq taken pc_sel", 32'(ex_pc_sel), 32'd1);
    chk("beq taken pc_we", 32'(ex_pc_we), 32'd1);
    chk("beq alu_ctrl", 32'(ex_alu_ctrl), 32'd1);
    do_instr(7'b1100011, 3'b000, 7'b0000000, 1'b0, 0, 0, "beq not taken");
    chk("beq nt pc_sel", 32'(ex_pc_sel), 32'd0);
    chk("beq nt pc_we", 32'(ex_pc_we), 32'd1);

    do_instr(7'b1100111, 3'b000, 7'b0000000, 1'b0, 0, 0, "jalr");
    chk("jalr wb pc_sel", 32'(wb_pc_sel), 32'd2);
    chk("jalr wb_sel", 32'(wb_wb_sel), 32'd2);
    do_instr(7'b0010011, 3'b101, 7'b0100000, 1'b0, 0, 0, "srai");
    chk("srai alu_ctrl", 32'(ex_alu_ctrl), 32'd7);
    chk("srai alu_src", 32'(ex_alu_src), 32'd1);
    do_instr(7'b0010111, 3'b000, 7'b0000000, 1'b0, 0, 0, "auipc");
    chk("auipc alu_a_sel", 32'(ex_alu_a_sel), 32'd1);
    chk("auipc imm_sel", 32'(ex_imm_sel), 32'd3);
    do_instr(7'b1101111, 3'b000, 7'b0000000, 1'b0, 0, 0, "jal");
    chk("jal wb pc_sel", 32'(wb_pc_sel), 32'd1);

    // Reset asserted in WB must suppress the writes of that cycle
    opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000000; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort in wb", 32'(fsm_state), 32'(ST_WB));
    rst_n = 1'b0;
    #1;
    chk("abort rf_we", 32'(rf_we), 32'd0);
    chk("abort pc_we", 32'(pc_we), 32'd0);
    chk("abort instret", 32'(instret), 32'd0);
    @(posedge clk); #1;
    chk("abort state", 32'(fsm_state), 32'(ST_FETCH));
    rst_n = 1'b1;

    // Illegal opcode traps after DECODE and stays there
    opcode = 7'b1111111;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("illegal fetch", 32'(fsm_state), 32'(ST_FETCH));
    @(posedge clk); #1;
    @(negedge clk);
    chk("illegal decode", 32'(fsm_state), 32'(ST_DECODE));
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("illegal state", 32'(fsm_state), 32'(ST_TRAP));
      chk("illegal trap", 32'(trap), 32'd1);
      chk("illegal cause", 32'(trap_cause), 32'd1);
      chk("illegal strobes", 32'({mem_req, ir_we, pc_we, rf_we, instret}), 32'd0);
      @(posedge clk); #1;
    end
    reset_pulse();

    // Bus timeout in FETCH after 16 cycles without ready
    opcode = 7'b0110011;
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("timeout wait state", 32'(fsm_state), 32'(ST_FETCH));
      chk("timeout ir_we", 32'(ir_we), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("timeout state", 32'(fsm_state), 32'(ST_TRAP));
    chk("timeout cause", 32'(trap_cause), 32'd2);
    chk("timeout trap", 32'(trap), 32'd1);
    reset_pulse();

    // Ready arriving on the 16th cycle beats the timeout
    do_instr(7'b0110011, 3'b000, 7'b0000000, 1'b0, 15, 0, "late ready");
    chk("late ready trap", 32'(trap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
